// File: rtl/mem_responder_pkg.sv
// Shared types and constants for the memory responder.
// Word width, default read latency and sequencer states.
package mem_responder_pkg;

  localparam int WORD_W          = 16;
  localparam int DEFAULT_LATENCY = 4;

  typedef enum logic {
    INIT,
    READY
  } state_t;

endpackage

// File: rtl/mem_resp_pipe.sv
// In-order read response pipeline: LATENCY stages of {valid, data}.
// Empty slots carry zero data so the output is clean when idle.
module mem_resp_pipe
  import mem_responder_pkg::*;
#(
  parameter int LATENCY = DEFAULT_LATENCY
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [WORD_W-1:0] in_data,
  output logic              out_valid,
  output logic [WORD_W-1:0] out_data
);

  logic [LATENCY-1:0] vld;
  logic [WORD_W-1:0]  dat [LATENCY];

  always_ff @(posedge clk) begin
    if (rst) begin
      vld <= '0;
      for (int i = 0; i < LATENCY; i++)
        dat[i] <= '0;
    end else begin
      vld[0] <= in_valid;
      dat[0] <= in_valid ? in_data : '0;
      for (int i = 1; i < LATENCY; i++) begin
        vld[i] <= vld[i-1];
        dat[i] <= dat[i-1];
      end
    end
  end

  assign out_valid = vld[LATENCY-1];
  assign out_data  = dat[LATENCY-1];

endmodule

// File: rtl/mem_responder.sv
// Word memory with zeroing init sequencer and fixed-latency
// in-order read responses.
module mem_responder
  import mem_responder_pkg::*;
#(
  parameter int ADDR_W  = 10,
  parameter int LATENCY = DEFAULT_LATENCY
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             req_valid,
  output logic                             req_ready,
  input  logic                             req_wr,
  input  logic [15:0]                      req_addr,
  input  logic [15:0]                      req_data,
  output logic                             resp_valid,
  output logic [15:0]                      resp_data,
  output logic [$clog2(LATENCY+1)-1:0]     outstanding
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam int CNT_W = $clog2(LATENCY + 1);

  state_t              state;
  logic [ADDR_W-1:0]   init_idx;
  logic [WORD_W-1:0]   mem [DEPTH];
  logic [ADDR_W-1:0]   widx;
  logic [WORD_W-1:0]   rd_data;
  logic                accept;
  logic                rd_acc;
  logic                wr_acc;
  logic [15:0]         unused_addr;

  // Byte address: bit 0 and bits above the array are dropped.
  assign widx        = req_addr[ADDR_W:1];
  assign unused_addr = req_addr;
  assign accept      = req_valid & req_ready & ~rst;
  assign rd_acc      = accept & ~req_wr;
  assign wr_acc      = accept & req_wr;
  assign rd_data     = mem[widx];

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= INIT;
      init_idx  <= '0;
      req_ready <= 1'b0;
    end else begin
      unique case (state)
        INIT: begin
          init_idx <= init_idx + ADDR_W'(1);
          if (init_idx == '1) begin
            state     <= READY;
            req_ready <= 1'b1;
          end
        end
        READY: req_ready <= 1'b1;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (state == INIT)
      mem[init_idx] <= '0;
    else if (wr_acc)
      mem[widx] <= req_data;
  end

  always_ff @(posedge clk) begin
    if (rst)
      outstanding <= '0;
    else if (rd_acc && !resp_valid)
      outstanding <= outstanding + CNT_W'(1);
    else if (!rd_acc && resp_valid)
      outstanding <= outstanding - CNT_W'(1);
  end

  mem_resp_pipe #(
    .LATENCY (LATENCY)
  ) u_pipe (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (rd_acc),
    .in_data   (rd_data),
    .out_valid (resp_valid),
    .out_data  (resp_data)
  );

endmodule
